// File: rtl/i2c_data_fifo_sync.sv
// ---------------------------------------------------------------------------
// i2c_data_fifo_sync
//
// Single-clock TX/RX data buffer pair for the I2C controller, used when the
// APB side and the I2C core run from the same clock. Each direction is an
// independent FIFO with an exact fill level, flush, and first-word
// fall-through head output. Programmable almost thresholds, combinational
// status flags and sticky write-1-to-clear error flags are provided.
//
// Ports
//   pclk_i           clock shared by both FIFOs
//   rst_ni           asynchronous active-low reset
//   data_from_apb_i  TX write data        tx_winc_i       TX write request
//   r_tx_fifo_en_i   TX pop request       data_to_sda_o   TX head word
//   data_from_sda_i  RX write data        w_rx_fifo_en_i  RX write request
//   rx_rinc_i        RX pop request       data_to_apb_o   RX head word
//   tx_flush_i       TX flush             rx_flush_i      RX flush
//   tx_ae_thr_i      TX almost-empty threshold (level <= thr)
//   rx_af_thr_i      RX almost-full threshold  (level >= thr)
//   err_clr_i        write-1-to-clear for err_o
//   tx_level_o       TX entry count 0..DEPTH
//   rx_level_o       RX entry count 0..DEPTH
//   status_o         {tx_empty, tx_full, tx_ae, tx_af,
//                     rx_empty, rx_full, rx_ae, rx_af}
//   err_o            {tx_overflow, tx_underflow, rx_overflow, rx_underflow}
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// i2c_data_fifo_core
//
// One synchronous FIFO with an authoritative level counter. Reports rejected
// writes/pops as single-cycle pulses so the parent can keep sticky errors.
//
// Ports
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   wr_en_i         write request, wdata_i write data
//   rd_en_i         pop request
//   flush_i         zero pointers and level on the next edge
//   rdata_o         head word, 0 while empty
//   level_o         entry count 0..DEPTH
//   wr_rej_o        write requested but not accepted this cycle
//   rd_rej_o        pop requested but not accepted this cycle
// ---------------------------------------------------------------------------
module i2c_data_fifo_core #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                rd_en_i,
    input  logic                flush_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic [ADDRSIZE:0]   level_o,
    output logic                wr_rej_o,
    output logic                rd_rej_o
);

    localparam int DEPTH = 2 ** ADDRSIZE;

    localparam logic [ADDRSIZE:0]   LVL_FULL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0]   LVL_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE-1:0] PTR_ONE  = {{(ADDRSIZE-1){1'b0}}, 1'b1};

    logic [DATASIZE-1:0] mem_q [DEPTH];

    logic [ADDRSIZE-1:0] wptr_q, wptr_d;
    logic [ADDRSIZE-1:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0]   level_q, level_d;

    logic wr_acc;
    logic rd_acc;

    // A pop needs a stored word, so a write into an empty FIFO cannot be
    // popped in the same cycle. A pop frees a slot, so a full FIFO can still
    // take a write when a pop is accepted alongside it.
    always_comb begin
        rd_acc = rd_en_i && (level_q != '0);
        wr_acc = wr_en_i && ((level_q != LVL_FULL) || rd_acc);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + LVL_ONE;
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - LVL_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage carries no reset; the head output is masked while empty.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o  = (level_q != '0) ? mem_q[rptr_q] : '0;
    assign level_o  = level_q;
    assign wr_rej_o = wr_en_i && !wr_acc;
    assign rd_rej_o = rd_en_i && !rd_acc;

endmodule

// ---------------------------------------------------------------------------
// Top level: TX and RX FIFOs, status flags and sticky error register.
// ---------------------------------------------------------------------------
module i2c_data_fifo_sync #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                pclk_i,
    input  logic                rst_ni,
    input  logic [DATASIZE-1:0] data_from_apb_i,
    input  logic                tx_winc_i,
    input  logic                r_tx_fifo_en_i,
    output logic [DATASIZE-1:0] data_to_sda_o,
    input  logic [DATASIZE-1:0] data_from_sda_i,
    input  logic                w_rx_fifo_en_i,
    input  logic                rx_rinc_i,
    output logic [DATASIZE-1:0] data_to_apb_o,
    input  logic                tx_flush_i,
    input  logic                rx_flush_i,
    input  logic [ADDRSIZE:0]   tx_ae_thr_i,
    input  logic [ADDRSIZE:0]   rx_af_thr_i,
    input  logic [3:0]          err_clr_i,
    output logic [ADDRSIZE:0]   tx_level_o,
    output logic [ADDRSIZE:0]   rx_level_o,
    output logic [7:0]          status_o,
    output logic [3:0]          err_o
);

    localparam logic [ADDRSIZE:0] LVL_FULL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] LVL_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE:0] LVL_AF   = LVL_FULL - LVL_ONE;

    logic [ADDRSIZE:0] tx_level;
    logic [ADDRSIZE:0] rx_level;
    logic              tx_wr_rej, tx_rd_rej;
    logic              rx_wr_rej, rx_rd_rej;

    logic [3:0] err_set;
    logic [3:0] err_q, err_d;

    i2c_data_fifo_core #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_tx_fifo (
        .clk_i    (pclk_i),
        .rst_ni   (rst_ni),
        .wr_en_i  (tx_winc_i),
        .wdata_i  (data_from_apb_i),
        .rd_en_i  (r_tx_fifo_en_i),
        .flush_i  (tx_flush_i),
        .rdata_o  (data_to_sda_o),
        .level_o  (tx_level),
        .wr_rej_o (tx_wr_rej),
        .rd_rej_o (tx_rd_rej)
    );

    i2c_data_fifo_core #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_rx_fifo (
        .clk_i    (pclk_i),
        .rst_ni   (rst_ni),
        .wr_en_i  (w_rx_fifo_en_i),
        .wdata_i  (data_from_sda_i),
        .rd_en_i  (rx_rinc_i),
        .flush_i  (rx_flush_i),
        .rdata_o  (data_to_apb_o),
        .level_o  (rx_level),
        .wr_rej_o (rx_wr_rej),
        .rd_rej_o (rx_rd_rej)
    );

    assign tx_level_o = tx_level;
    assign rx_level_o = rx_level;

    // Thresholds above DEPTH need no special handling: the compares already
    // saturate to almost-empty = 1 and almost-full = 0.
    assign status_o[7] = (tx_level == '0);
    assign status_o[6] = (tx_level == LVL_FULL);
    assign status_o[5] = (tx_level <= tx_ae_thr_i);
    assign status_o[4] = (tx_level >= LVL_AF);
    assign status_o[3] = (rx_level == '0);
    assign status_o[2] = (rx_level == LVL_FULL);
    assign status_o[1] = (rx_level <= LVL_ONE);
    assign status_o[0] = (rx_level >= rx_af_thr_i);

    assign err_set = {tx_wr_rej, tx_rd_rej, rx_wr_rej, rx_rd_rej};

    // A new error event in the same cycle as its clear leaves the bit set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_err
        assign err_d[gi] = err_set[gi] | (err_q[gi] & ~err_clr_i[gi]);
    end

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_i2c_data_fifo_sync.sv
module tb_i2c_data_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_from_apb;
    logic       tx_winc;
    logic       r_tx_fifo_en;
    logic [7:0] data_to_sda;
    logic [7:0] data_from_sda;
    logic       w_rx_fifo_en;
    logic       rx_rinc;
    logic [7:0] data_to_apb;
    logic       tx_flush;
    logic       rx_flush;
    logic [4:0] tx_ae_thr;
    logic [4:0] rx_af_thr;
    logic [3:0] err_clr;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic [7:0] status;
    logic [3:0] err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] model_q[$];

    i2c_data_fifo_sync #(
        .DATASIZE (8),
        .ADDRSIZE (4)
    ) dut (
        .pclk_i          (clk),
        .rst_ni          (rst_n),
        .data_from_apb_i (data_from_apb),
        .tx_winc_i       (tx_winc),
        .r_tx_fifo_en_i  (r_tx_fifo_en),
        .data_to_sda_o   (data_to_sda),
        .data_from_sda_i (data_from_sda),
        .w_rx_fifo_en_i  (w_rx_fifo_en),
        .rx_rinc_i       (rx_rinc),
        .data_to_apb_o   (data_to_apb),
        .tx_flush_i      (tx_flush),
        .rx_flush_i      (rx_flush),
        .tx_ae_thr_i     (tx_ae_thr),
        .rx_af_thr_i     (rx_af_thr),
        .err_clr_i       (err_clr),
        .tx_level_o      (tx_level),
        .rx_level_o      (rx_level),
        .status_o        (status),
        .err_o           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        data_from_apb = '0;
        tx_winc       = 1'b0;
        r_tx_fifo_en  = 1'b0;
        data_from_sda = '0;
        w_rx_fifo_en  = 1'b0;
        rx_rinc       = 1'b0;
        tx_flush      = 1'b0;
        rx_flush      = 1'b0;
        tx_ae_thr     = 5'd2;
        rx_af_thr     = 5'd16;
        err_clr       = 4'b0000;

        // Reset state
        #22;
        chk("rst_status", status, 8'hAA);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step();
        chk("idle_status", status, 8'hAA);
        chk("idle_sda_data", data_to_sda, 0);
        chk("idle_apb_data", data_to_apb, 0);

        // TX fill to full
        tx_winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_from_apb = 8'(i);
            step();
        end
        tx_winc = 1'b0;
        chk("tx_full_level", tx_level, 16);
        chk("tx_full_flag", status[6], 1);
        chk("tx_af_flag", status[4], 1);
        chk("tx_full_head", data_to_sda, 8'h00);

        // 17th write is dropped
        tx_winc = 1'b1;
        data_from_apb = 8'h55;
        step();
        tx_winc = 1'b0;
        chk("tx_ovf_level", tx_level, 16);
        chk("tx_ovf_err", err, 4'b1000);

        // Drain in order
        r_tx_fifo_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_pop%0d", i), data_to_sda, i);
            step();
        end
        r_tx_fifo_en = 1'b0;
        chk("tx_drained_empty", status[7], 1);
        chk("tx_drained_level", tx_level, 0);
        chk("tx_drained_data", data_to_sda, 0);

        // Underflow with a same-cycle clear: set wins
        r_tx_fifo_en = 1'b1;
        err_clr      = 4'b0100;
        step();
        r_tx_fifo_en = 1'b0;
        err_clr      = 4'b0000;
        chk("tx_unf_set_wins", err, 4'b1100);
        err_clr = 4'b1100;
        step();
        err_clr = 4'b0000;
        chk("tx_err_cleared", err, 0);

        // RX fill, then 20 cycles of simultaneous write and pop across wrap
        w_rx_fifo_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_from_sda = 8'h10 + 8'(i);
            model_q.push_back(data_from_sda);
            step();
        end
        chk("rx_full_level", rx_level, 16);
        rx_rinc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_from_sda = 8'h40 + 8'(i);
            chk($sformatf("rx_wrap%0d", i), data_to_apb, model_q[0]);
            void'(model_q.pop_front());
            model_q.push_back(data_from_sda);
            step();
        end
        w_rx_fifo_en = 1'b0;
        rx_rinc      = 1'b0;
        chk("rx_wrap_level", rx_level, 16);
        chk("rx_wrap_err", err, 0);
        chk("rx_wrap_head", data_to_apb, model_q[0]);

        // RX flush
        rx_flush = 1'b1;
        step();
        rx_flush = 1'b0;
        chk("rx_flush_level", rx_level, 0);
        chk("rx_flush_empty", status[3], 1);
        chk("rx_flush_data", data_to_apb, 0);

        // Empty RX: write and pop together
        w_rx_fifo_en  = 1'b1;
        rx_rinc       = 1'b1;
        data_from_sda = 8'hA5;
        step();
        w_rx_fifo_en = 1'b0;
        rx_rinc      = 1'b0;
        chk("rx_unf_err", err, 4'b0001);
        chk("rx_unf_level", rx_level, 1);
        chk("rx_unf_data", data_to_apb, 8'hA5);
        err_clr = 4'b0001;
        step();
        err_clr = 4'b0000;
        chk("rx_unf_clear", err, 0);
        rx_rinc = 1'b1;
        step();
        rx_rinc = 1'b0;
        chk("rx_pop_last", rx_level, 0);

        // TX almost-empty threshold
        tx_ae_thr = 5'd4;
        tx_winc   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_from_apb = 8'h60 + 8'(i);
            step();
        end
        tx_winc = 1'b0;
        chk("tx_ae_lvl5", status[5], 0);
        r_tx_fifo_en = 1'b1;
        step();
        r_tx_fifo_en = 1'b0;
        chk("tx_ae_lvl4", status[5], 1);
        chk("tx_head_after_pop", data_to_sda, 8'h61);
        tx_ae_thr = 5'd3;
        #1;
        chk("tx_ae_thr3", status[5], 0);
        tx_ae_thr = 5'd31;
        #1;
        chk("tx_ae_thr31", status[5], 1);

        // RX almost-full threshold
        rx_af_thr    = 5'd3;
        w_rx_fifo_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_from_sda = 8'h70 + 8'(i);
            step();
            chk($sformatf("rx_af_w%0d", i), status[0], (i == 2) ? 1 : 0);
        end
        w_rx_fifo_en = 1'b0;
        chk("rx_ae_lvl3", status[1], 0);
        rx_af_thr = 5'd20;
        #1;
        chk("rx_af_thr20", status[0], 0);

        // TX flush at level 7 overrides a same-cycle write
        tx_winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_from_apb = 8'h80 + 8'(i);
            step();
        end
        chk("tx_lvl7", tx_level, 7);
        tx_flush = 1'b1;
        data_from_apb = 8'h99;
        step();
        tx_flush = 1'b0;
        tx_winc  = 1'b0;
        chk("tx_flush_level", tx_level, 0);
        chk("tx_flush_empty", status[7], 1);
        chk("tx_flush_rx_level", rx_level, 3);
        chk("tx_flush_rx_data", data_to_apb, 8'h70);
        chk("tx_flush_err", err, 0);

        // Asynchronous reset in the middle of a transfer
        r_tx_fifo_en = 1'b1;
        step();
        r_tx_fifo_en = 1'b0;
        chk("pre_rst_err", err, 4'b0100);
        tx_winc = 1'b1;
        data_from_apb = 8'hC3;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_status", status, 8'hAA);
        chk("arst_tx_level", tx_level, 0);
        chk("arst_rx_level", rx_level, 0);
        chk("arst_err", err, 0);
        chk("arst_sda_data", data_to_sda, 0);
        chk("arst_apb_data", data_to_apb, 0);
        tx_winc = 1'b0;
        #10;
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_data_fifo_sync.md
Name: i2c_data_fifo_sync

Overview:
Single-clock, parametrised TX/RX data buffer pair for the I2C controller, for builds where the APB and I2C core share one clock, so no pointer synchronisers are needed. The TX FIFO is written from APB and read by the data path toward SDA. The RX FIFO is written from SDA and read by APB. Additions over the dual-clock buffer:
- exact fill levels
- programmable almost thresholds
- per-FIFO flush
- sticky overflow/underflow error flags with write-1-to-clear

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 4, log2 of depth per FIFO (DEPTH = 2**ADDRSIZE = 16)

Ports:
pclk_i  in  1  single clock for both FIFOs
rst_ni  in  1  asynchronous active-low reset
data_from_apb_i  in  DATASIZE  TX write data
tx_winc_i  in  1  TX write request
r_tx_fifo_en_i  in  1  TX read request (pop)
data_to_sda_o  out  DATASIZE  TX head word (first-word fall-through)
data_from_sda_i  in  DATASIZE  RX write data
w_rx_fifo_en_i  in  1  RX write request
rx_rinc_i  in  1  RX read request (pop)
data_to_apb_o  out  DATASIZE  RX head word (first-word fall-through)
tx_flush_i  in  1  synchronous TX flush
rx_flush_i  in  1  synchronous RX flush
tx_ae_thr_i  in  ADDRSIZE+1  TX almost-empty threshold
rx_af_thr_i  in  ADDRSIZE+1  RX almost-full threshold
err_clr_i  in  4  write-1-to-clear for err_o bits
tx_level_o  out  ADDRSIZE+1  TX entry count, 0..DEPTH
rx_level_o  out  ADDRSIZE+1  RX entry count, 0..DEPTH
status_o  out  8  [7] tx_empty [6] tx_full [5] tx_almost_empty [4] tx_almost_full [3] rx_empty [2] rx_full [1] rx_almost_empty [0] rx_almost_full
err_o  out  4  sticky flags: [3] tx_overflow [2] tx_underflow [1] rx_overflow [0] rx_underflow

Behaviour:
Interface and reset:
- One clock, pclk_i. Reset rst_ni is asynchronous, active-low.
- On reset: all pointers = 0, levels = 0, err_o = 0.
- status_o = 8'b1010_1010 after reset (both FIFOs empty and almost-empty).
- data outputs = 0 after reset. Memory contents are not reset.

FIFO structure (identical for TX and RX):
- Register array of DEPTH words.
- wptr and rptr are ADDRSIZE bits wide and wrap modulo DEPTH.
- level is ADDRSIZE+1 bits wide and is the authoritative count.

Write and read rules:
- Write accepted iff request && (level < DEPTH || pop accepted in the same cycle). An accepted write stores data at wptr and increments wptr.
- Pop accepted iff request && level > 0. An accepted pop increments rptr.
- A write into an empty FIFO cannot be popped in the same cycle.
- Level update per cycle: +1 (write only), -1 (pop only), 0 (both or neither).
- Simultaneous write and pop when full: both accepted, level stays at DEPTH.
- Simultaneous write and pop when empty: write accepted, pop rejected, underflow set, level becomes 1.

Read data:
- Head data = mem[rptr] when level > 0, else 0.
- Data is combinational from registered state, so a written word is visible on the head output the cycle after the write.

Flags:
- empty = (level == 0); full = (level == DEPTH).
- tx_almost_empty = (tx_level <= tx_ae_thr_i); tx_almost_full = (tx_level >= DEPTH-1).
- rx_almost_full = (rx_level >= rx_af_thr_i); rx_almost_empty = (rx_level <= 1).
- All flags are combinational from registered level and thresholds. A threshold change takes effect immediately.

Errors:
- Overflow sets when a write is rejected. Underflow sets when a pop is rejected.
- Error bits are sticky until reset or err_clr_i.
- If a set event and a clear for the same bit occur in the same cycle, set wins.

Flush:
- Flush zeroes wptr, rptr and level on the next edge, overriding any same-cycle write or pop to that FIFO.
- Flush does not clear err_o. It does not touch the other FIFO.

Threshold range:
- Thresholds > DEPTH are legal: almost-empty is then always 1, almost-full always 0.

Test Plan:
- Reset, then idle -> status_o=8'hAA, levels 0, err_o=0, data outputs 0.
- Write 16 TX words 8'h00..8'h0F -> tx_level 16, status_o[6]=1 and [4]=1. 17th write -> dropped, err_o[3]=1. Pop 16 times -> data_to_sda_o sequence 00..0F, then status_o[7]=1.
- RX filled to 16, then simultaneous w_rx_fifo_en_i and rx_rinc_i for 20 cycles -> level stays 16, no overflow, output order preserved across pointer wrap.
- RX empty, simultaneous write 8'hA5 and pop -> err_o[0]=1, rx_level 1, data_to_apb_o=8'hA5 next cycle. err_clr_i=4'b0001 -> err_o[0]=0.
- tx_ae_thr_i=4 with TX level 5 -> almost_empty 0. Pop once -> 1. Set rx_af_thr_i=3 and write 3 RX words -> status_o[0]=1 on the third.
- TX at level 7 with tx_flush_i and tx_winc_i together -> tx_level 0, empty=1, rx_level unchanged. Assert rst_ni low mid-transfer -> all outputs return to reset values asynchronously.
